serial_axi_bridge: RTL and testbench



---
 rtl/serial_axi_bridge.sv | 266 ++++++++++++++++++++++++++
 tb/tb_serial_axi_bridge.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_axi_bridge.sv
// UART byte-command parser driving single-beat AXI4 writes/reads into the MIG slave port.
// Optional rx inactivity timeout is enabled with `define SERIAL_AXI_RX_TIMEOUT_EN.
module serial_axi_bridge #(
    parameter int          ADDR_WIDTH     = 28,
    parameter int          AXI_DATA_WIDTH = 128,
    parameter logic [23:0] RX_TIMEOUT     = 24'd1000000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  rx_data,
    input  logic                        rx_valid,
    output logic                        rx_ready,
    output logic [7:0]                  tx_data,
    output logic                        tx_valid,
    input  logic                        tx_ready,
    output logic [ADDR_WIDTH-1:0]       m_axi_awaddr,
    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                        m_axi_wlast,
    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready,
    input  logic [1:0]                  m_axi_bresp,
    input  logic                        m_axi_bvalid,
    output logic                        m_axi_bready,
    output logic [ADDR_WIDTH-1:0]       m_axi_araddr,
    output logic                        m_axi_arvalid,
    input  logic                        m_axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                  m_axi_rresp,
    input  logic                        m_axi_rvalid,
    output logic                        m_axi_rready,
    output logic [2:0]                  state_dbg
);

    // Every valid/ready pair transfers on a rising edge where both are high; valids are
    // registered, never depend on the matching ready, and hold their payload until taken.

    localparam int LANES     = AXI_DATA_WIDTH / 32;
    localparam int LANE_BITS = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [7:0] CMD_WRITE   = 8'h57;
    localparam logic [7:0] CMD_READ    = 8'h52;
    localparam logic [7:0] RSP_UNKNOWN = 8'h3F;
    localparam logic [7:0] RSP_TIMEOUT = 8'h54;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_WDATA, S_WR_ADDR_DATA, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_TX
    } state_t;

    state_t        state;
    logic [1:0]    cnt;
    logic          is_write;
    logic [31:0]   addr_reg;
    logic [31:0]   data_reg;
    logic [39:0]   tx_shift;
    logic [2:0]    tx_left;

    logic [31:0]          addr_next;
    logic [31:0]          data_next;
    logic [LANE_BITS-1:0] lane_sel;
    int                   lane_idx;
    logic [AXI_DATA_WIDTH/8-1:0] strb_sel;
    logic [31:0]          rd_word;
    logic                 rx_fire;
    logic                 rx_timeout;

    assign state_dbg   = state;
    assign m_axi_wlast = 1'b1;
    assign rx_fire     = rx_valid && rx_ready;
    assign addr_next   = {addr_reg[23:0], rx_data};
    assign data_next   = {data_reg[23:0], rx_data};

    generate
        if (LANES > 1) begin : g_lane
            assign lane_sel = addr_reg[LANE_BITS+1:2];
        end else begin : g_single_lane
            assign lane_sel = '0;
        end
    endgenerate

    assign lane_idx = int'(lane_sel);

    always_comb begin
        strb_sel                   = '0;
        strb_sel[lane_idx*4 +: 4]  = 4'hF;
        rd_word                    = m_axi_rdata[lane_idx*32 +: 32];
    end

    function automatic logic [ADDR_WIDTH-1:0] eff_addr(input logic [31:0] a);
        return {a[ADDR_WIDTH-1:2], 2'b00};
    endfunction

    function automatic logic [7:0] status_of(input logic [1:0] resp);
        return (resp == 2'b00) ? 8'h00 : {6'b100000, resp};
    endfunction

`ifdef SERIAL_AXI_RX_TIMEOUT_EN
    logic [23:0] idle_cnt;

    always_ff @(posedge clk) begin
        if (rst || !(state == S_ADDR || state == S_WDATA) || rx_fire) begin
            idle_cnt <= '0;
        end else if (!rx_timeout) begin
            idle_cnt <= idle_cnt + 24'd1;
        end
    end

    assign rx_timeout = (idle_cnt == RX_TIMEOUT);
`else
    logic unused_rx_timeout_param;
    assign unused_rx_timeout_param = ^RX_TIMEOUT;
    assign rx_timeout              = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            is_write      <= 1'b0;
            addr_reg      <= '0;
            data_reg      <= '0;
            tx_shift      <= '0;
            tx_left       <= '0;
            rx_ready      <= 1'b0;
            tx_data       <= '0;
            tx_valid      <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    rx_ready <= 1'b1;
                    if (rx_fire) begin
                        cnt <= '0;
                        if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
                            is_write <= (rx_data == CMD_WRITE);
                            state    <= S_ADDR;
                        end else begin
                            state    <= S_TX;
                            rx_ready <= 1'b0;
                            tx_valid <= 1'b1;
                            tx_data  <= RSP_UNKNOWN;
                            tx_shift <= {RSP_UNKNOWN, 32'h0};
                            tx_left  <= 3'd1;
                        end
                    end
                end

                S_ADDR: begin
                    if (rx_fire) begin
                        addr_reg <= addr_next;
                        cnt      <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            if (is_write) begin
                                state <= S_WDATA;
                            end else begin
                                state         <= S_RD_ADDR;
                                rx_ready      <= 1'b0;
                                m_axi_araddr  <= eff_addr(addr_next);
                                m_axi_arvalid <= 1'b1;
                            end
                        end
                    end else if (rx_timeout) begin
                        state    <= S_TX;
                        rx_ready <= 1'b0;
                        tx_valid <= 1'b1;
                        tx_data  <= RSP_TIMEOUT;
                        tx_shift <= {RSP_TIMEOUT, 32'h0};
                        tx_left  <= 3'd1;
                    end
                end

                S_WDATA: begin
                    if (rx_fire) begin
                        data_reg <= data_next;
                        cnt      <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            // Address is complete here, so lane_sel/strb_sel are final.
                            state         <= S_WR_ADDR_DATA;
                            rx_ready      <= 1'b0;
                            m_axi_awaddr  <= eff_addr(addr_reg);
                            m_axi_wdata   <= {LANES{data_next}};
                            m_axi_wstrb   <= strb_sel;
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                        end
                    end else if (rx_timeout) begin
                        state    <= S_TX;
                        rx_ready <= 1'b0;
                        tx_valid <= 1'b1;
                        tx_data  <= RSP_TIMEOUT;
                        tx_shift <= {RSP_TIMEOUT, 32'h0};
                        tx_left  <= 3'd1;
                    end
                end

                S_WR_ADDR_DATA: begin
                    if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
                    if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
                    if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
                        state        <= S_WR_RESP;
                        m_axi_bready <= 1'b1;
                    end
                end

                S_WR_RESP: begin
                    if (m_axi_bvalid && m_axi_bready) begin
                        m_axi_bready <= 1'b0;
                        state        <= S_TX;
                        tx_valid     <= 1'b1;
                        tx_data      <= status_of(m_axi_bresp);
                        tx_shift     <= {status_of(m_axi_bresp), 32'h0};
                        tx_left      <= 3'd1;
                    end
                end

                S_RD_ADDR: begin
                    if (m_axi_arvalid && m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= S_RD_DATA;
                    end
                end

                S_RD_DATA: begin
                    if (m_axi_rvalid && m_axi_rready) begin
                        m_axi_rready <= 1'b0;
                        state        <= S_TX;
                        tx_valid     <= 1'b1;
                        tx_data      <= status_of(m_axi_rresp);
                        tx_shift     <= {status_of(m_axi_rresp), rd_word};
                        tx_left      <= 3'd5;
                    end
                end

                S_TX: begin
                    if (tx_valid && tx_ready) begin
                        if (tx_left == 3'd1) begin
                            tx_valid <= 1'b0;
                            tx_left  <= '0;
                            rx_ready <= 1'b1;
                            state    <= S_IDLE;
                        end else begin
                            // tx_shift[39:32] is the byte just sent; next one sits below it.
                            tx_data  <= tx_shift[31:24];
                            tx_shift <= tx_shift << 8;
                            tx_left  <= tx_left - 3'd1;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_axi_bridge.sv
// Directed bench for serial_axi_bridge: vector table of write/read commands plus
// hand-written sequences for unknown bytes, tx back-pressure and reset in RD_DATA.
module tb_serial_axi_bridge;

    localparam int AW = 28;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [AW-1:0] m_axi_awaddr;
    logic          m_axi_awvalid;
    logic          m_axi_awready;
    logic [DW-1:0] m_axi_wdata;
    logic [DW/8-1:0] m_axi_wstrb;
    logic          m_axi_wlast;
    logic          m_axi_wvalid;
    logic          m_axi_wready;
    logic [1:0]    m_axi_bresp;
    logic          m_axi_bvalid;
    logic          m_axi_bready;
    logic [AW-1:0] m_axi_araddr;
    logic          m_axi_arvalid;
    logic          m_axi_arready;
    logic [DW-1:0] m_axi_rdata;
    logic [1:0]    m_axi_rresp;
    logic          m_axi_rvalid;
    logic          m_axi_rready;
    logic [2:0]    state_dbg;

    serial_axi_bridge #(.ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit           is_write;
        logic [31:0]  addr;
        logic [31:0]  data;
        logic [127:0] rdata;
        logic [1:0]   resp;
        int           aw_dly;
        int           w_dly;
        logic [27:0]  exp_addr;
        logic [15:0]  exp_strb;
        logic [7:0]   exp_status;
        logic [31:0]  exp_word;
    } vec_t;

    vec_t vecs[7];

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 50) begin
            tick();
            n++;
        end
        chk("rx_accept", rx_ready, 1'b1);
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic recv_byte(output logic [7:0] b);
        int n;
        n = 0;
        tx_ready = 1'b1;
        while (!tx_valid && n < 50) begin
            tick();
            n++;
        end
        chk("tx_valid_wait", tx_valid, 1'b1);
        b = tx_data;
        tick();
        tx_ready = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] cmd, input logic [31:0] addr);
        send_byte(cmd);
        for (int i = 3; i >= 0; i--) send_byte(addr[8*i +: 8]);
    endtask

    task automatic run_write(input vec_t v);
        int c, aw_hi, w_hi;
        bit aw_done, w_done, early, hs_aw, hs_w;
        logic [27:0]  g_addr;
        logic [127:0] g_data;
        logic [15:0]  g_strb;
        logic [7:0]   b;
        c = 0; aw_hi = 0; w_hi = 0;
        aw_done = 0; w_done = 0; early = 0;
        g_addr = '0; g_data = '0; g_strb = '0;
        send_cmd(8'h57, v.addr);
        for (int i = 3; i >= 0; i--) send_byte(v.data[8*i +: 8]);
        chk("aw_w_latency", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
        while (!(aw_done && w_done) && c < 100) begin
            if (m_axi_bready) early = 1;
            m_axi_awready = !aw_done && (c >= v.aw_dly);
            m_axi_wready  = !w_done && (c >= v.w_dly);
            if (m_axi_awvalid) aw_hi++;
            if (m_axi_wvalid) w_hi++;
            hs_aw = m_axi_awvalid && m_axi_awready;
            hs_w  = m_axi_wvalid && m_axi_wready;
            if (hs_aw) g_addr = m_axi_awaddr;
            if (hs_w) begin
                g_data = m_axi_wdata;
                g_strb = m_axi_wstrb;
            end
            tick();
            if (hs_aw) aw_done = 1;
            if (hs_w) w_done = 1;
            c++;
        end
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        chk("awaddr", g_addr, v.exp_addr);
        chk("wstrb", g_strb, v.exp_strb);
        chk("wdata", g_data, {4{v.data}});
        chk("awvalid_cycles", aw_hi, v.aw_dly + 1);
        chk("wvalid_cycles", w_hi, v.w_dly + 1);
        chk("bready_early", early, 1'b0);
        chk("bready_after_hs", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 3'b001);
        m_axi_bresp  = v.resp;
        m_axi_bvalid = 1'b1;
        tick();
        m_axi_bvalid = 1'b0;
        m_axi_bresp  = 2'b00;
        chk("bready_drop", m_axi_bready, 1'b0);
        recv_byte(b);
        chk("wr_status", b, v.exp_status);
        chk("b2b_ready", rx_ready, 1'b1);
    endtask

    task automatic read_axi(input vec_t v);
        int n;
        n = 0;
        send_cmd(8'h52, v.addr);
        while (!m_axi_arvalid && n < 50) begin
            tick();
            n++;
        end
        chk("arvalid", m_axi_arvalid, 1'b1);
        chk("araddr", m_axi_araddr, v.exp_addr);
        m_axi_arready = 1'b1;
        tick();
        m_axi_arready = 1'b0;
        chk("ar_to_r", {m_axi_arvalid, m_axi_rready}, 2'b01);
        m_axi_rdata  = v.rdata;
        m_axi_rresp  = v.resp;
        m_axi_rvalid = 1'b1;
        tick();
        m_axi_rvalid = 1'b0;
        m_axi_rdata  = '0;
        m_axi_rresp  = 2'b00;
        chk("rready_drop", m_axi_rready, 1'b0);
    endtask

    task automatic run_read(input vec_t v);
        logic [7:0]  b;
        logic [39:0] got;
        got = '0;
        read_axi(v);
        for (int i = 0; i < 5; i++) begin
            recv_byte(b);
            got = {got[31:0], b};
        end
        chk("rd_tx", got, {v.exp_status, v.exp_word});
        chk("b2b_ready", rx_ready, 1'b1);
    endtask

    task automatic run_vec(input vec_t v);
        if (v.is_write) run_write(v);
        else run_read(v);
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {rx_ready, tx_valid, tx_data, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                   m_axi_arvalid, m_axi_rready, state_dbg}, 18'h0);
        chk({name, "_addr"}, {m_axi_awaddr, m_axi_araddr, m_axi_wstrb}, 72'h0);
        chk({name, "_wdata"}, m_axi_wdata, 128'h0);
    endtask

    // ---------------- test ----------------
    initial begin
        logic [7:0]  b;
        logic [39:0] got;
        bit          stable;

        //          wr addr          data          rdata                                      resp   aw w  exp_addr       strb      stat   word
        vecs[0] = '{1, 32'h00000014, 32'hDEADBEEF, 128'h0,                                    2'b00, 0, 0, 28'h0000014, 16'h00F0, 8'h00, 32'h0};
        vecs[1] = '{0, 32'h00000014, 32'h0,        128'h33333333_22222222_DEADBEEF_44444444, 2'b00, 0, 0, 28'h0000014, 16'h0,    8'h00, 32'hDEADBEEF};
        vecs[2] = '{1, 32'hF234567B, 32'hCAFEF00D, 128'h0,                                    2'b00, 5, 0, 28'h2345678, 16'h0F00, 8'h00, 32'h0};
        vecs[3] = '{1, 32'h0000000C, 32'h01020304, 128'h0,                                    2'b10, 0, 3, 28'h000000C, 16'hF000, 8'h82, 32'h0};
        vecs[4] = '{0, 32'h00000008, 32'h0,        128'hAAAAAAAA_12345678_BBBBBBBB_CCCCCCCC, 2'b10, 0, 0, 28'h0000008, 16'h0,    8'h82, 32'h12345678};
        vecs[5] = '{1, 32'h00000000, 32'hA5A55A5A, 128'h0,                                    2'b11, 2, 2, 28'h0000000, 16'h000F, 8'h83, 32'h0};
        vecs[6] = '{0, 32'hFFFFFFFF, 32'h0,        128'h0BADF00D_11111111_22222222_33333333, 2'b01, 0, 0, 28'hFFFFFFC, 16'h0,    8'h81, 32'h0BADF00D};

        rst = 1'b1;
        rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bresp = 2'b00; m_axi_bvalid = 1'b0;
        m_axi_arready = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00; m_axi_rvalid = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset_outputs");
        chk("wlast_const", m_axi_wlast, 1'b1);
        rst = 1'b0;
        tick();
        chk("idle_ready", {rx_ready, state_dbg}, 4'b1000);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Unknown command byte, then a normal write.
        send_byte(8'h41);
        recv_byte(b);
        chk("unknown_rsp", b, 8'h3F);
        chk("unknown_idle", {rx_ready, state_dbg}, 4'b1000);
        run_vec(vecs[0]);

        // tx back-pressure for 10 cycles after the status byte of a read.
        read_axi(vecs[1]);
        recv_byte(b);
        got = {32'h0, b};
        stable = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!(tx_valid === 1'b1 && tx_data === vecs[1].exp_word[31:24])) stable = 0;
        end
        chk("stall_hold", stable, 1'b1);
        for (int i = 0; i < 4; i++) begin
            recv_byte(b);
            got = {got[31:0], b};
        end
        chk("stall_tx", got, {vecs[1].exp_status, vecs[1].exp_word});
        chk("stall_no_dup", tx_valid, 1'b0);

        // Reset while waiting for read data.
        send_cmd(8'h52, 32'h00000014);
        m_axi_arready = 1'b1;
        tick();
        m_axi_arready = 1'b0;
        chk("in_rd_data", {state_dbg, m_axi_rready}, 4'b1101);
        rst = 1'b1;
        tick();
        chk_all_zero("rst_in_rd_data");
        rst = 1'b0;
        tick();
        chk("post_rst_ready", {rx_ready, state_dbg}, 4'b1000);
        run_vec(vecs[5]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
